// File: rtl/rs_complex_pkg.sv
// rtl/rs_complex_pkg.sv - shared widths, entry field layout and CDB wakeup helper
package rs_complex_pkg;

    localparam int ENTRY_W = 114;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;

    // Entry field positions, shared by dispatch, the station and ex_complex
    localparam int WRADDR_LSB  = 0;
    localparam int RDY1        = 5;
    localparam int OP1_LSB     = 6;
    localparam int RDY2        = 38;
    localparam int OP2_LSB     = 39;
    localparam int REGWRITE    = 71;
    localparam int BRANCH      = 72;
    localparam int MEMTOREG    = 73;
    localparam int MEMREAD     = 74;
    localparam int MEMWRITE    = 75;
    localparam int ALUOP_LSB   = 76;
    localparam int MEMDATA_LSB = 82;

    // Captures CDB results into any still-waiting source; cdb0 is checked first so it wins a tie
    function automatic logic [ENTRY_W-1:0] wake_entry(
        input logic [ENTRY_W-1:0] e,
        input logic               c0_valid,
        input logic [TAG_W-1:0]   c0_tag,
        input logic [DATA_W-1:0]  c0_data,
        input logic               c1_valid,
        input logic [TAG_W-1:0]   c1_tag,
        input logic [DATA_W-1:0]  c1_data
    );
        logic [ENTRY_W-1:0] r;
        r = e;
        if (!e[RDY1]) begin
            if (c0_valid && (c0_tag == e[OP1_LSB +: TAG_W])) begin
                r[OP1_LSB +: DATA_W] = c0_data;
                r[RDY1]              = 1'b1;
            end else if (c1_valid && (c1_tag == e[OP1_LSB +: TAG_W])) begin
                r[OP1_LSB +: DATA_W] = c1_data;
                r[RDY1]              = 1'b1;
            end
        end
        if (!e[RDY2]) begin
            if (c0_valid && (c0_tag == e[OP2_LSB +: TAG_W])) begin
                r[OP2_LSB +: DATA_W] = c0_data;
                r[RDY2]              = 1'b1;
            end else if (c1_valid && (c1_tag == e[OP2_LSB +: TAG_W])) begin
                r[OP2_LSB +: DATA_W] = c1_data;
                r[RDY2]              = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_complex_slot.sv
// rtl/rs_complex_slot.sv - one reservation station entry with dual-CDB wakeup and issue clear
module rs_slot
    import rs_complex_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [ENTRY_W-1:0] load_entry,
    input  logic [TAG_W-1:0]   load_rob,
    input  logic               issue,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [DATA_W-1:0]  cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [DATA_W-1:0]  cdb1_data,
    output logic               valid,
    output logic [ENTRY_W-1:0] entry,
    output logic [TAG_W-1:0]   rob
);

    // Slot state: flush > load into empty slot > issue > wakeup of a resident entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
            rob   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            entry <= '0;
            rob   <= '0;
        end else if (load && !valid) begin
            valid <= 1'b1;
            entry <= wake_entry(load_entry, cdb0_valid, cdb0_tag, cdb0_data,
                                cdb1_valid, cdb1_tag, cdb1_data);
            rob   <= load_rob;
        end else if (valid && issue) begin
            valid <= 1'b0;
            entry <= '0;
            rob   <= '0;
        end else if (valid) begin
            entry <= wake_entry(entry, cdb0_valid, cdb0_tag, cdb0_data,
                                cdb1_valid, cdb1_tag, cdb1_data);
        end
    end

endmodule

// File: rtl/rs_complex.sv
// rtl/rs_complex.sv - two-entry reservation station for the complex execution pipe
module rs_complex
    import rs_complex_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               dispatch_valid,
    input  logic [ENTRY_W-1:0] dispatch_entry,
    input  logic [TAG_W-1:0]   dispatch_rob_num,
    output logic               dispatch_ready,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [DATA_W-1:0]  cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [DATA_W-1:0]  cdb1_data,
    input  logic               complex_0_issue,
    input  logic               complex_1_issue,
    output logic [ENTRY_W-1:0] rs_complex_0,
    output logic [ENTRY_W-1:0] rs_complex_1,
    output logic [TAG_W-1:0]   rs_complex_0_entry_num,
    output logic [TAG_W-1:0]   rs_complex_1_entry_num,
    output logic               selector
);

    logic               valid0, valid1;
    logic [ENTRY_W-1:0] entry0, entry1;
    logic [TAG_W-1:0]   rob0, rob1;
    logic               accept, load0, load1;

    // Allocation uses current state only, so a slot freed by issue this cycle is not reused
    assign dispatch_ready = ~(valid0 & valid1);
    assign accept         = dispatch_valid & dispatch_ready & ~flush;
    assign load0          = accept & ~valid0;
    assign load1          = accept & valid0 & ~valid1;

    rs_slot u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (load0),
        .load_entry (dispatch_entry),
        .load_rob   (dispatch_rob_num),
        .issue      (complex_0_issue),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb0_data  (cdb0_data),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_data  (cdb1_data),
        .valid      (valid0),
        .entry      (entry0),
        .rob        (rob0)
    );

    rs_slot u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (load1),
        .load_entry (dispatch_entry),
        .load_rob   (dispatch_rob_num),
        .issue      (complex_1_issue),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb0_data  (cdb0_data),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_data  (cdb1_data),
        .valid      (valid1),
        .entry      (entry1),
        .rob        (rob1)
    );

    // Selector points at the most recently filled slot; issue leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selector <= 1'b0;
        end else if (flush) begin
            selector <= 1'b0;
        end else if (accept) begin
            selector <= load1;
        end
    end

    // Empty slots present all zeros so rdy bits read 0 and ex cannot issue them
    assign rs_complex_0           = valid0 ? entry0 : '0;
    assign rs_complex_1           = valid1 ? entry1 : '0;
    assign rs_complex_0_entry_num = valid0 ? rob0 : '0;
    assign rs_complex_1_entry_num = valid1 ? rob1 : '0;

endmodule
